// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one word per frame from the show-ahead TX FIFO
// and shifts it out as start / 5-8 data bits (LSB first) / optional parity or
// ninth-bit slot / 1-2 stop bits. Frame configuration is frozen at launch.
module uart_tx_serializer #(
   parameter int unsigned DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [DIV_WIDTH-1:0] brd,
   input  logic [1:0]           data_size,
   input  logic [2:0]           parity_mode,
   input  logic                 stop2,
   input  logic [8:0]           fifo_data,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_request,
   output logic                 tx,
   output logic                 busy
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t               state, state_n;
   logic [DIV_WIDTH-1:0] timer, timer_n;
   logic [DIV_WIDTH-1:0] period_r, period_n;
   logic [2:0]           bit_cnt, bit_cnt_n;
   logic [8:0]           data_r, data_n;
   logic [1:0]           size_r, size_n;
   logic [2:0]           pmode_r, pmode_n;
   logic                 stop2_r, stop2_n;
   logic                 tx_n, busy_n, rd_n;

   logic [DIV_WIDTH-1:0] brd_eff;
   logic                 launch_ok;
   logic                 do_launch;
   logic                 bit_done;
   logic                 last_data;
   logic                 parity_on;
   logic [7:0]           data_mask;
   logic                 even_par;
   logic                 parity_bit;

   assign brd_eff   = (brd == '0) ? DIV_WIDTH'(1) : brd;
   assign launch_ok = enable & ~fifo_empty;
   assign bit_done  = (timer == '0);
   assign last_data = (bit_cnt == (3'd4 + 3'(size_r)));
   assign parity_on = (pmode_r >= 3'd1) && (pmode_r <= 3'd5);
   assign data_mask = 8'hFF >> (2'd3 - size_r);
   assign even_par  = ^(data_r[7:0] & data_mask);

   // Parity / ninth-bit slot value for the frame in flight
   always_comb begin
      parity_bit = 1'b1;
      case (pmode_r)
         3'd1:    parity_bit = even_par;
         3'd2:    parity_bit = ~even_par;
         3'd3:    parity_bit = 1'b1;
         3'd4:    parity_bit = 1'b0;
         3'd5:    parity_bit = data_r[8];
         default: parity_bit = 1'b1;
      endcase
   end

   // Next-state, bit timing and registered-output values
   always_comb begin
      state_n   = state;
      timer_n   = bit_done ? timer : timer - DIV_WIDTH'(1);
      period_n  = period_r;
      bit_cnt_n = bit_cnt;
      data_n    = data_r;
      size_n    = size_r;
      pmode_n   = pmode_r;
      stop2_n   = stop2_r;
      tx_n      = tx;
      busy_n    = busy;
      rd_n      = 1'b0;
      do_launch = 1'b0;

      case (state)
         IDLE: begin
            do_launch = launch_ok;
         end
         START: begin
            if (bit_done) begin
               state_n   = DATA;
               timer_n   = period_r - DIV_WIDTH'(1);
               bit_cnt_n = '0;
               tx_n      = data_r[0];
            end
         end
         DATA: begin
            if (bit_done) begin
               timer_n = period_r - DIV_WIDTH'(1);
               if (last_data) begin
                  bit_cnt_n = '0;
                  if (parity_on) begin
                     state_n = PARITY;
                     tx_n    = parity_bit;
                  end else begin
                     state_n = STOP;
                     tx_n    = 1'b1;
                  end
               end else begin
                  bit_cnt_n = bit_cnt + 3'd1;
                  tx_n      = data_r[3'(bit_cnt + 3'd1)];
               end
            end
         end
         PARITY: begin
            if (bit_done) begin
               state_n   = STOP;
               timer_n   = period_r - DIV_WIDTH'(1);
               bit_cnt_n = '0;
               tx_n      = 1'b1;
            end
         end
         STOP: begin
            if (bit_done) begin
               if (stop2_r && (bit_cnt == 3'd0)) begin
                  bit_cnt_n = 3'd1;
                  timer_n   = period_r - DIV_WIDTH'(1);
               end else if (launch_ok) begin
                  do_launch = 1'b1;
               end else begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
                  tx_n    = 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
            tx_n    = 1'b1;
         end
      endcase

      // Launch is shared by IDLE and the last stop-bit boundary so that
      // back-to-back frames start on the same edge the previous one ends.
      if (do_launch) begin
         state_n   = START;
         data_n    = fifo_data;
         size_n    = data_size;
         pmode_n   = parity_mode;
         stop2_n   = stop2;
         period_n  = brd_eff;
         timer_n   = brd_eff - DIV_WIDTH'(1);
         bit_cnt_n = '0;
         tx_n      = 1'b0;
         busy_n    = 1'b1;
         rd_n      = 1'b1;
      end
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state           <= IDLE;
         timer           <= '0;
         period_r        <= DIV_WIDTH'(1);
         bit_cnt         <= '0;
         data_r          <= '0;
         size_r          <= '0;
         pmode_r         <= '0;
         stop2_r         <= 1'b0;
         tx              <= 1'b1;
         busy            <= 1'b0;
         fifo_rd_request <= 1'b0;
      end else begin
         state           <= state_n;
         timer           <= timer_n;
         period_r        <= period_n;
         bit_cnt         <= bit_cnt_n;
         data_r          <= data_n;
         size_r          <= size_n;
         pmode_r         <= pmode_n;
         stop2_r         <= stop2_n;
         tx              <= tx_n;
         busy            <= busy_n;
         fifo_rd_request <= rd_n;
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with a small show-ahead FIFO model.
module tb_uart_tx_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] brd;
   logic [1:0]  data_size;
   logic [2:0]  parity_mode;
   logic        stop2;
   logic [8:0]  fifo_data;
   logic        fifo_empty;
   logic        fifo_rd_request;
   logic        tx;
   logic        busy;

   int checks = 0;
   int passed = 0;

   // FIFO model: pushes from the stimulus tasks, pops on the DUT strobe
   logic [8:0]  mem [0:15];
   int unsigned wr_ptr = 0;
   int unsigned rd_ptr = 0;
   int          pops = 0;
   int          underflows = 0;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_data  = mem[rd_ptr[3:0]];

   // Captured per-cycle waveforms, oldest sample in the higher bits
   logic [127:0] obs_tx, obs_busy, obs_rd, exp_w;
   int           pops0;

   uart_tx_serializer #(.DIV_WIDTH(16)) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .brd(brd),
      .data_size(data_size),
      .parity_mode(parity_mode),
      .stop2(stop2),
      .fifo_data(fifo_data),
      .fifo_empty(fifo_empty),
      .fifo_rd_request(fifo_rd_request),
      .tx(tx),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Pop the head word on each strobe; a strobe against an empty FIFO is logged
   always @(posedge clk) begin
      if (fifo_rd_request) begin
         pops <= pops + 1;
         if (fifo_empty) underflows <= underflows + 1;
         else            rd_ptr <= rd_ptr + 1;
      end
   end

   task automatic push(input logic [8:0] w);
      mem[wr_ptr[3:0]] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic clear_capture();
      obs_tx   = '0;
      obs_busy = '0;
      obs_rd   = '0;
   endtask

   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         obs_tx   = {obs_tx[126:0], tx};
         obs_busy = {obs_busy[126:0], busy};
         obs_rd   = {obs_rd[126:0], fifo_rd_request};
      end
   endtask

   // Appends n listed bits (first in time = bits[n-1]), each held p cycles
   function automatic logic [127:0] app(input logic [127:0] w, input logic [63:0] bits,
                                        input int n, input int p);
      logic [127:0] r;
      r = w;
      for (int i = n - 1; i >= 0; i--)
         for (int j = 0; j < p; j++)
            r = {r[126:0], bits[i]};
      return r;
   endfunction

   task automatic set_cfg(input logic [15:0] b, input logic [1:0] ds, input logic [2:0] pm,
                          input logic s2);
      brd = b; data_size = ds; parity_mode = pm; stop2 = s2;
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b1;
      set_cfg(16'd4, 2'd3, 3'd0, 1'b0);
      repeat (3) @(negedge clk);
      checks++; if (tx !== 1'b1) $display("FAIL reset_tx got %b exp 1", tx); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
      checks++; if (fifo_rd_request !== 1'b0) $display("FAIL reset_rd got %b exp 0", fifo_rd_request); else passed++;
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_8n1();
      set_cfg(16'd4, 2'd3, 3'd0, 1'b0);
      pops0 = pops;
      push(9'h055);
      clear_capture();
      capture(42);
      exp_w = app(app('0, 64'(10'b0101010101), 10, 4), 64'(2'b11), 2, 1);
      checks++; if (obs_tx !== exp_w) $display("FAIL 8n1_tx got %b exp %b", obs_tx, exp_w); else passed++;
      exp_w = app(app('0, 64'd1, 1, 40), 64'd0, 1, 2);
      checks++; if (obs_busy !== exp_w) $display("FAIL 8n1_busy got %b exp %b", obs_busy, exp_w); else passed++;
      exp_w = app(app('0, 64'd1, 1, 1), 64'd0, 1, 41);
      checks++; if (obs_rd !== exp_w) $display("FAIL 8n1_rd got %b exp %b", obs_rd, exp_w); else passed++;
      checks++; if (pops - pops0 !== 1) $display("FAIL 8n1_pops got %0d exp 1", pops - pops0); else passed++;
   endtask

   task automatic test_parity();
      set_cfg(16'd2, 2'd2, 3'd1, 1'b1);
      pops0 = pops;
      push(9'h003);
      clear_capture();
      capture(24);
      exp_w = app(app('0, 64'(11'b01100000011), 11, 2), 64'(2'b11), 2, 1);
      checks++; if (obs_tx !== exp_w) $display("FAIL even_tx got %b exp %b", obs_tx, exp_w); else passed++;
      parity_mode = 3'd2;
      push(9'h003);
      clear_capture();
      capture(24);
      exp_w = app(app('0, 64'(11'b01100000111), 11, 2), 64'(2'b11), 2, 1);
      checks++; if (obs_tx !== exp_w) $display("FAIL odd_tx got %b exp %b", obs_tx, exp_w); else passed++;
      exp_w = app(app('0, 64'd1, 1, 22), 64'd0, 1, 2);
      checks++; if (obs_busy !== exp_w) $display("FAIL odd_busy got %b exp %b", obs_busy, exp_w); else passed++;
      checks++; if (pops - pops0 !== 2) $display("FAIL parity_pops got %0d exp 2", pops - pops0); else passed++;
   endtask

   task automatic test_back_to_back();
      set_cfg(16'd3, 2'd3, 3'd5, 1'b0);
      pops0 = pops;
      push(9'h1A5);
      push(9'h0A5);
      clear_capture();
      capture(68);
      exp_w = app(app('0, 64'({11'b01010010111, 11'b01010010101}), 22, 3), 64'(2'b11), 2, 1);
      checks++; if (obs_tx !== exp_w) $display("FAIL ninth_tx got %b exp %b", obs_tx, exp_w); else passed++;
      exp_w = app(app('0, 64'd1, 1, 66), 64'd0, 1, 2);
      checks++; if (obs_busy !== exp_w) $display("FAIL ninth_busy got %b exp %b", obs_busy, exp_w); else passed++;
      exp_w = app(app(app(app('0, 64'd1, 1, 1), 64'd0, 1, 32), 64'd1, 1, 1), 64'd0, 1, 34);
      checks++; if (obs_rd !== exp_w) $display("FAIL ninth_rd got %b exp %b", obs_rd, exp_w); else passed++;
      checks++; if (pops - pops0 !== 2) $display("FAIL ninth_pops got %0d exp 2", pops - pops0); else passed++;
   endtask

   task automatic test_brd_zero();
      set_cfg(16'd0, 2'd0, 3'd0, 1'b0);
      push(9'h01F);
      clear_capture();
      capture(9);
      exp_w = app(app('0, 64'(7'b0111111), 7, 1), 64'(2'b11), 2, 1);
      checks++; if (obs_tx !== exp_w) $display("FAIL brd0_tx got %b exp %b", obs_tx, exp_w); else passed++;
      exp_w = app(app('0, 64'd1, 1, 7), 64'd0, 1, 2);
      checks++; if (obs_busy !== exp_w) $display("FAIL brd0_busy got %b exp %b", obs_busy, exp_w); else passed++;
      exp_w = app(app('0, 64'd1, 1, 1), 64'd0, 1, 8);
      checks++; if (obs_rd !== exp_w) $display("FAIL brd0_rd got %b exp %b", obs_rd, exp_w); else passed++;
   endtask

   task automatic test_enable_mid_frame();
      set_cfg(16'd2, 2'd3, 3'd0, 1'b0);
      pops0 = pops;
      push(9'h0F0);
      push(9'h033);
      clear_capture();
      capture(9);
      enable = 1'b0;
      brd    = 16'd3;
      capture(21);
      exp_w = app(app('0, 64'(10'b0000011111), 10, 2), 64'd1, 1, 10);
      checks++; if (obs_tx !== exp_w) $display("FAIL endis_tx got %b exp %b", obs_tx, exp_w); else passed++;
      exp_w = app(app('0, 64'd1, 1, 20), 64'd0, 1, 10);
      checks++; if (obs_busy !== exp_w) $display("FAIL endis_busy got %b exp %b", obs_busy, exp_w); else passed++;
      exp_w = app(app('0, 64'd1, 1, 1), 64'd0, 1, 29);
      checks++; if (obs_rd !== exp_w) $display("FAIL endis_rd got %b exp %b", obs_rd, exp_w); else passed++;
      checks++; if (pops - pops0 !== 1) $display("FAIL endis_pops got %0d exp 1", pops - pops0); else passed++;
      enable = 1'b1;
      clear_capture();
      capture(32);
      exp_w = app(app('0, 64'(10'b0110011001), 10, 3), 64'(2'b11), 2, 1);
      checks++; if (obs_tx !== exp_w) $display("FAIL reen_tx got %b exp %b", obs_tx, exp_w); else passed++;
      checks++; if (pops - pops0 !== 2) $display("FAIL reen_pops got %0d exp 2", pops - pops0); else passed++;
      checks++; if (fifo_empty !== 1'b1) $display("FAIL reen_empty got %b exp 1", fifo_empty); else passed++;
   endtask

   task automatic test_reset_mid_frame();
      set_cfg(16'd2, 2'd3, 3'd0, 1'b0);
      pops0 = pops;
      push(9'h000);
      push(9'h081);
      clear_capture();
      capture(6);
      reset = 1'b0;
      capture(2);
      exp_w = app(app('0, 64'd0, 1, 6), 64'd1, 1, 2);
      checks++; if (obs_tx !== exp_w) $display("FAIL rstmid_tx got %b exp %b", obs_tx, exp_w); else passed++;
      exp_w = app(app('0, 64'd1, 1, 6), 64'd0, 1, 2);
      checks++; if (obs_busy !== exp_w) $display("FAIL rstmid_busy got %b exp %b", obs_busy, exp_w); else passed++;
      exp_w = app(app('0, 64'd1, 1, 1), 64'd0, 1, 7);
      checks++; if (obs_rd !== exp_w) $display("FAIL rstmid_rd got %b exp %b", obs_rd, exp_w); else passed++;
      checks++; if (pops - pops0 !== 1) $display("FAIL rstmid_pops got %0d exp 1", pops - pops0); else passed++;
      reset = 1'b1;
      clear_capture();
      capture(22);
      exp_w = app(app('0, 64'(10'b0100000011), 10, 2), 64'(2'b11), 2, 1);
      checks++; if (obs_tx !== exp_w) $display("FAIL rstrel_tx got %b exp %b", obs_tx, exp_w); else passed++;
      checks++; if (pops - pops0 !== 2) $display("FAIL rstrel_pops got %0d exp 2", pops - pops0); else passed++;
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_back_to_back();
      test_brd_zero();
      test_enable_mid_frame();
      test_reset_mid_frame();
      repeat (2) @(negedge clk);
      checks++; if (underflows !== 0) $display("FAIL no_underflow got %0d exp 0", underflows); else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit serializer that sits directly downstream of the 16-entry x 9-bit TX FIFO in the serial IP.
- Pops one 9-bit word per frame from the FIFO's show-ahead read port and shifts it out on a single TX line.
- Frame format: start bit, 5-8 data bits (LSB first), optional parity or 9th-bit slot, then 1 or 2 stop bits.
- Frame configuration and bit-rate divisor come from the IP's control registers.

Parameters:
- DIV_WIDTH, 16, width of the bit-period divisor input and the internal bit timer.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  transmitter enable from the control register.
- brd  input  DIV_WIDTH  clk cycles per bit; 0 is treated as 1.
- data_size  input  2  encodings 0..3 select 5, 6, 7, 8 data bits.
- parity_mode  input  3  0 none; 1 even; 2 odd; 3 mark (1); 4 space (0); 5 ninth-bit (slot carries fifo_data[8]); 6-7 treated as none.
- stop2  input  1  1 selects 2 stop bits, 0 selects 1.
- fifo_data  input  9  FIFO head word; valid combinationally whenever fifo_empty=0.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_request  output  1  one-cycle pop strobe to the FIFO.
- tx  output  1  serial line; idle level is 1.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE, tx=1, busy=0, fifo_rd_request=0, bit timer and bit counter cleared. Reset mid-frame aborts the frame; tx returns to 1 on that same edge and no partial bits follow.
- States: IDLE -> START -> DATA -> PARITY (only if the parity slot is enabled) -> STOP -> IDLE or START.
- Frame launch, edge N: in IDLE with enable=1 and fifo_empty=0:
  - capture fifo_data into the shift register;
  - latch data_size, parity_mode, stop2 and brd;
  - assert fifo_rd_request for exactly one cycle (edge N to N+1);
  - tx=0 and busy=1 from edge N; next state is START.
- Bit timing: every bit (start, data, parity, each stop bit) holds tx for exactly max(brd_latched,1) clk cycles. The timer reloads at each bit boundary.
- Configuration changes mid-frame take effect only at the next frame launch.
- DATA: bits sent LSB first; exactly 5+data_size bits. Bit 8 is never sent as data.
- PARITY slot value:
  - even: XOR of the sent data bits only;
  - odd: inverse of even;
  - mark: 1; space: 0;
  - ninth-bit: captured bit 8.
- STOP: tx=1 for 1 or 2 bit periods. On the last stop-bit boundary:
  - if enable=1 and fifo_empty=0, launch the next frame at that same edge (back-to-back, no idle gap), with a pop strobe as above;
  - otherwise go to IDLE with busy=0.
- enable deasserted mid-frame: the current frame completes normally, then IDLE. No new pop while enable=0.
- fifo_rd_request is never asserted when fifo_empty=0 is not sampled at the same edge. It is never asserted outside a launch edge, and never twice for one frame.
- Frame length in clk cycles = max(brd,1) x (1 + (5+data_size) + parity_on + 1 + stop2).

Test Plan:
- brd=4, 8N1, FIFO holds 0x055 -> one fifo_rd_request pulse; tx sequence per 4-cycle bit: 0,1,0,1,0,1,0,1,0,1; busy high for exactly 40 cycles; tx=1 after.
- brd=2, 7 bits, even parity, 2 stop, data 0x003 -> bits 0, 1,1,0,0,0,0,0, parity 0, stop 1,1; 22 cycles. Repeat with odd parity -> parity bit 1.
- brd=3, parity_mode=5, 8 bits, FIFO words 0x1A5 then 0x0A5 -> first frame ninth slot=1, second=0; exactly 2 pops; second start bit begins on the edge the first frame's stop ends (no gap).
- brd=0, 5N1, data 0x01F -> each bit lasts 1 cycle: 0,1,1,1,1,1,1; frame is 7 cycles.
- Mid-frame at data bit 3: deassert enable with 2 words queued -> current frame completes, no further pops, tx stays 1. Re-enable -> next word sent.
- Reset asserted mid-DATA -> tx=1, busy=0, no pop at the next edge; after release with FIFO non-empty, a new frame starts cleanly.
